// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with one synchronous write port,
// two registered read ports, write-to-read bypass and a sequential clear engine.
module regfile_2r1w #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_req,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   input  logic             clr,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   state_t           state, state_nxt;
   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_ok;
   logic             rd_ok;
   logic [WIDTH-1:0] rd_nxt_a;
   logic [WIDTH-1:0] rd_nxt_b;

   assign busy  = (state == CLEAR);
   assign rd_ok = rd_req && (state == IDLE);

   // Write acceptance: idle, in range, and not the hardwired zero entry.
   always_comb begin
      wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < DEPTH_W);
      if ((ZERO_REG != 0) && (wr_addr == '0))
         wr_ok = 1'b0;
   end

   // Port A read value: out-of-range and zero entry read 0, same-edge write bypasses.
   always_comb begin
      rd_nxt_a = '0;
      if (({1'b0, rd_addr_a} < DEPTH_W) && !((ZERO_REG != 0) && (rd_addr_a == '0))) begin
         if (wr_ok && (wr_addr == rd_addr_a))
            rd_nxt_a = wr_data;
         else
            rd_nxt_a = mem[rd_addr_a];
      end
   end

   // Port B read value: same rules as port A, evaluated independently.
   always_comb begin
      rd_nxt_b = '0;
      if (({1'b0, rd_addr_b} < DEPTH_W) && !((ZERO_REG != 0) && (rd_addr_b == '0))) begin
         if (wr_ok && (wr_addr == rd_addr_b))
            rd_nxt_b = wr_data;
         else
            rd_nxt_b = mem[rd_addr_b];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next state: clr starts the sweep, the edge clearing the last entry ends it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr) state_nxt = CLEAR;
         CLEAR:   if (cnt == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Clear counter: walks 0..DEPTH-1 while clearing, parked at 0 otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (state == CLEAR)
         cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
   end

   // Storage: one entry zeroed per clear cycle; otherwise accepted writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i[AW-1:0]] <= '0;
      end else if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read outputs: data held until the next accepted request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid  <= 1'b0;
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            rd_data_a <= rd_nxt_a;
            rd_data_b <= rd_nxt_b;
         end
      end
   end

endmodule
